// File: rtl/cache_status_pkg.sv
// cache_status_pkg: shared FSM state type and default geometry for cache_status_array.
package cache_status_pkg;
   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
   localparam int CS_WAYS = 4;
   localparam int CS_SETS = 16;
endpackage

// File: rtl/way_bit_mux.sv
// way_bit_mux: selects one way's bit out of a WAYS-wide status vector.
module way_bit_mux #(
   parameter int WAYS = 4,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]  vec,
   input  logic [WAY_W-1:0] sel,
   output logic             y
);
   assign y = vec[sel];
endmodule

// File: rtl/cache_status_array.sv
// cache_status_array: per-set valid/dirty status store with registered reads and an invalidate-all sweep.
// Dirty array is built only when CACHE_STATUS_DIRTY_EN is defined; otherwise dirty outputs read 0.
module cache_status_array
   import cache_status_pkg::*;
#(
   parameter int WAYS = CS_WAYS,
   parameter int SETS = CS_SETS,
   localparam int WAY_W = $clog2(WAYS),
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_set,
   input  logic [WAY_W-1:0] rd_way,
   output logic             rd_resp,
   output logic [WAYS-1:0]  rd_valid_vec,
   output logic [WAYS-1:0]  rd_dirty_vec,
   output logic             rd_valid_bit,
   output logic             rd_dirty_bit,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_set,
   input  logic [WAY_W-1:0] wr_way,
   input  logic             wr_valid,
   input  logic             wr_dirty,
   input  logic             inv_req,
   output logic             inv_busy,
   output logic             inv_done
);
   state_t           state;
   logic [IDX_W-1:0] cnt;
   logic [WAY_W-1:0] rd_way_q;
   logic [WAYS-1:0]  valid [SETS];
   logic [WAYS-1:0]  valid_nxt;
   logic             wr_ok, wr_hit, clr_hit;
   assign wr_ok   = wr_en && state == IDLE;
   assign wr_hit  = wr_ok && wr_set == rd_set;
   assign clr_hit = state == SWEEP && cnt == rd_set;
   // Read sees this cycle's write or sweep clear (write-first)
   always_comb begin
      valid_nxt = valid[rd_set];
      if (wr_hit) valid_nxt[wr_way] = wr_valid;
      if (clr_hit) valid_nxt = '0;
   end
   always_ff @(posedge clk)
      if (!rst_n)
         for (int s = 0; s < SETS; s++) valid[s] <= '0;
      else begin
         if (state == SWEEP) valid[cnt] <= '0;
         if (wr_ok) valid[wr_set][wr_way] <= wr_valid;
      end
   always_ff @(posedge clk)
      if (!rst_n) begin
         rd_resp      <= 1'b0;
         rd_valid_vec <= '0;
         rd_way_q     <= '0;
      end else begin
         rd_resp <= rd_en;
         if (rd_en) begin
            rd_valid_vec <= valid_nxt;
            rd_way_q     <= rd_way;
         end
      end
   way_bit_mux #(.WAYS(WAYS)) u_valid_mux (.vec(rd_valid_vec), .sel(rd_way_q), .y(rd_valid_bit));
`ifdef CACHE_STATUS_DIRTY_EN
   logic [WAYS-1:0] dirty [SETS];
   logic [WAYS-1:0] dirty_nxt;
   always_comb begin
      dirty_nxt = dirty[rd_set];
      if (wr_hit) dirty_nxt[wr_way] = wr_dirty;
      if (clr_hit) dirty_nxt = '0;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) dirty[s] <= '0;
         rd_dirty_vec <= '0;
      end else begin
         if (state == SWEEP) dirty[cnt] <= '0;
         if (wr_ok) dirty[wr_set][wr_way] <= wr_dirty;
         if (rd_en) rd_dirty_vec <= dirty_nxt;
      end
   way_bit_mux #(.WAYS(WAYS)) u_dirty_mux (.vec(rd_dirty_vec), .sel(rd_way_q), .y(rd_dirty_bit));
`else
   logic unused_dirty;
   assign unused_dirty = wr_dirty;
   assign rd_dirty_vec = '0;
   assign rd_dirty_bit = 1'b0;
`endif
   // Counter holds at the last set; the terminal compare ends the sweep
   always_ff @(posedge clk)
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         inv_busy <= 1'b0;
         inv_done <= 1'b0;
      end else
         case (state)
            IDLE:
               if (inv_req) begin
                  state    <= SWEEP;
                  cnt      <= '0;
                  inv_busy <= 1'b1;
               end
            SWEEP:
               if (cnt == IDX_W'(SETS - 1)) begin
                  state    <= DONE;
                  inv_done <= 1'b1;
               end else
                  cnt <= cnt + 1'b1;
            DONE: begin
               state    <= IDLE;
               inv_busy <= 1'b0;
               inv_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_cache_status_array.sv
// tb_cache_status_array: directed and randomized checks of cache_status_array against a behavioural model.
// Dirty expectations follow CACHE_STATUS_DIRTY_EN the same way the design does.
module tb_cache_status_array;
   localparam int W = 4;
   localparam int S = 16;
`ifdef CACHE_STATUS_DIRTY_EN
   localparam bit DIRTY = 1'b1;
`else
   localparam bit DIRTY = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic rd_en = 1'b0, wr_en = 1'b0, wr_valid = 1'b0, wr_dirty = 1'b0, inv_req = 1'b0;
   logic [3:0] rd_set = '0, wr_set = '0;
   logic [1:0] rd_way = '0, wr_way = '0;
   logic rd_resp, rd_valid_bit, rd_dirty_bit, inv_busy, inv_done;
   logic [W-1:0] rd_valid_vec, rd_dirty_vec;
   bit mv [S][W];
   bit md [S][W];
   int mpos = -1;
   logic exp_resp = 0, exp_vb = 0, exp_db = 0, exp_busy = 0, exp_done = 0;
   logic [W-1:0] exp_vv = '0, exp_dv = '0;
   int checks = 0, errors = 0;

   cache_status_array #(.WAYS(W), .SETS(S)) dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_set(rd_set), .rd_way(rd_way),
      .rd_resp(rd_resp), .rd_valid_vec(rd_valid_vec), .rd_dirty_vec(rd_dirty_vec),
      .rd_valid_bit(rd_valid_bit), .rd_dirty_bit(rd_dirty_bit),
      .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_valid(wr_valid), .wr_dirty(wr_dirty),
      .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done));

   always #5 clk = ~clk;

   // mpos: -1 idle, 0..S-1 set being cleared this cycle, S is the done cycle
   task automatic step();
      if (mpos >= 0 && mpos < S)
         for (int w = 0; w < W; w++) begin mv[mpos][w] = 0; md[mpos][w] = 0; end
      if (wr_en && mpos < 0) begin
         mv[wr_set][wr_way] = wr_valid;
         md[wr_set][wr_way] = DIRTY & wr_dirty;
      end
      exp_resp = rd_en;
      if (rd_en) begin
         for (int w = 0; w < W; w++) begin exp_vv[w] = mv[rd_set][w]; exp_dv[w] = md[rd_set][w]; end
         exp_vb = mv[rd_set][rd_way];
         exp_db = md[rd_set][rd_way];
      end
      if (mpos < 0) mpos = inv_req ? 0 : -1;
      else if (mpos == S) mpos = -1;
      else mpos++;
      if (!rst_n) begin
         for (int s = 0; s < S; s++) for (int w = 0; w < W; w++) begin mv[s][w] = 0; md[s][w] = 0; end
         mpos = -1; exp_resp = 0; exp_vv = '0; exp_dv = '0; exp_vb = 0; exp_db = 0;
      end
      exp_busy = mpos >= 0;
      exp_done = mpos == S;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 0; step(); step(); rst_n = 1;
      checks++; if (rd_resp !== 1'b0 || rd_valid_vec !== '0 || rd_dirty_vec !== '0) begin errors++;
         $display("FAIL reset_read: resp=%b vv=%b dv=%b want 0/0000/0000", rd_resp, rd_valid_vec, rd_dirty_vec); end
      checks++; if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin errors++;
         $display("FAIL reset_inv: busy=%b done=%b want 0/0", inv_busy, inv_done); end
      rd_en = 1; rd_set = 3; rd_way = 2; step(); rd_en = 0;
      checks++; if (rd_resp !== 1'b1 || rd_valid_vec !== 4'b0000 || rd_dirty_vec !== 4'b0000 || rd_valid_bit !== 1'b0) begin errors++;
         $display("FAIL reset_first_read: resp=%b vv=%b dv=%b vb=%b want 1/0000/0000/0", rd_resp, rd_valid_vec, rd_dirty_vec, rd_valid_bit); end
      step();
      checks++; if (rd_resp !== 1'b0) begin errors++; $display("FAIL resp_pulse: resp=%b want 0", rd_resp); end
   endtask

   task automatic test_write_read();
      logic [W-1:0] dv_want;
      dv_want = DIRTY ? 4'b0010 : 4'b0000;
      wr_en = 1; wr_set = 5; wr_way = 1; wr_valid = 1; wr_dirty = 1; step(); wr_en = 0;
      rd_en = 1; rd_set = 5; rd_way = 1; step();
      checks++; if (rd_valid_vec !== 4'b0010 || rd_dirty_vec !== dv_want) begin errors++;
         $display("FAIL write_read_vec: vv=%b dv=%b want 0010/%b", rd_valid_vec, rd_dirty_vec, dv_want); end
      checks++; if (rd_valid_bit !== 1'b1 || rd_dirty_bit !== DIRTY) begin errors++;
         $display("FAIL write_read_bit: vb=%b db=%b want 1/%b", rd_valid_bit, rd_dirty_bit, DIRTY); end
      rd_way = 0; step(); rd_en = 0;
      checks++; if (rd_valid_bit !== 1'b0 || rd_dirty_bit !== 1'b0) begin errors++;
         $display("FAIL write_read_way0: vb=%b db=%b want 0/0", rd_valid_bit, rd_dirty_bit); end
   endtask

   task automatic test_bypass();
      wr_en = 1; wr_set = 7; wr_way = 3; wr_valid = 1; wr_dirty = 0;
      rd_en = 1; rd_set = 7; rd_way = 3; step(); wr_en = 0; rd_en = 0;
      checks++; if (rd_valid_vec !== 4'b1000 || rd_valid_bit !== 1'b1) begin errors++;
         $display("FAIL bypass: vv=%b vb=%b want 1000/1", rd_valid_vec, rd_valid_bit); end
   endtask

   task automatic test_sweep();
      int dones = 0;
      wr_en = 1; wr_valid = 1; wr_dirty = 1;
      for (int s = 0; s < S; s++) for (int w = 0; w < W; w++) begin wr_set = 4'(s); wr_way = 2'(w); step(); end
      wr_en = 0;
      rd_en = 1; rd_set = 9; step(); rd_en = 0;
      checks++; if (rd_valid_vec !== 4'b1111) begin errors++; $display("FAIL fill: vv=%b want 1111", rd_valid_vec); end
      inv_req = 1; step(); inv_req = 0;
      for (int k = 1; k <= S + 1; k++) begin
         checks++; if (inv_busy !== 1'b1 || inv_done !== (k == S + 1)) begin errors++;
            $display("FAIL sweep_k%0d: busy=%b done=%b want 1/%b", k, inv_busy, inv_done, k == S + 1); end
         wr_en = k == 3; wr_set = 0; wr_way = 0; inv_req = k == 5;
         step(); wr_en = 0; inv_req = 0;
      end
      checks++; if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin errors++;
         $display("FAIL sweep_end: busy=%b done=%b want 0/0", inv_busy, inv_done); end
      rd_en = 1;
      for (int s = 0; s <= S; s++) begin
         if (inv_done) dones++;
         rd_set = 4'(s % S); rd_way = 0; step();
         checks++; if (rd_valid_vec !== '0 || rd_dirty_vec !== '0 || rd_valid_vec !== exp_vv) begin errors++;
            $display("FAIL swept_set%0d: vv=%b dv=%b want 0000/0000", s % S, rd_valid_vec, rd_dirty_vec); end
      end
      rd_en = 0;
      checks++; if (dones != 0) begin errors++; $display("FAIL extra_done: pulses=%0d want 0", dones); end
   endtask

   task automatic test_reset_mid_sweep();
      wr_en = 1; wr_valid = 1; wr_dirty = 1; wr_way = 2;
      wr_set = 10; step(); wr_set = 15; step(); wr_en = 0;
      inv_req = 1; step(); inv_req = 0;
      for (int k = 1; k < 5; k++) step();
      rst_n = 0; step(); rst_n = 1;
      checks++; if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin errors++;
         $display("FAIL mid_reset: busy=%b done=%b want 0/0", inv_busy, inv_done); end
      rd_en = 1; rd_way = 2;
      for (int k = 0; k < S + 2; k++) begin
         rd_set = k[0] ? 4'd15 : 4'd10; step();
         checks++; if (inv_done !== 1'b0 || rd_valid_vec !== '0 || rd_valid_bit !== 1'b0) begin errors++;
            $display("FAIL mid_reset_read%0d: done=%b vv=%b vb=%b want 0/0000/0", k, inv_done, rd_valid_vec, rd_valid_bit); end
      end
      rd_en = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         rst_n = $urandom_range(0, 299) != 0;
         rd_en = $urandom_range(0, 2) != 0; rd_set = 4'($urandom); rd_way = 2'($urandom);
         wr_en = $urandom_range(0, 1) != 0; wr_set = 4'($urandom); wr_way = 2'($urandom);
         wr_valid = 1'($urandom); wr_dirty = 1'($urandom);
         if ($urandom_range(0, 3) == 0) wr_set = rd_set;
         inv_req = $urandom_range(0, 59) == 0;
         step();
         checks++; if (rd_resp !== exp_resp) begin errors++; $display("FAIL rnd%0d_resp: got %b want %b", n, rd_resp, exp_resp); end
         checks++; if (rd_valid_vec !== exp_vv || rd_valid_bit !== exp_vb) begin errors++;
            $display("FAIL rnd%0d_valid: got %b/%b want %b/%b", n, rd_valid_vec, rd_valid_bit, exp_vv, exp_vb); end
         checks++; if (rd_dirty_vec !== exp_dv || rd_dirty_bit !== exp_db) begin errors++;
            $display("FAIL rnd%0d_dirty: got %b/%b want %b/%b", n, rd_dirty_vec, rd_dirty_bit, exp_dv, exp_db); end
         checks++; if (inv_busy !== exp_busy || inv_done !== exp_done) begin errors++;
            $display("FAIL rnd%0d_inv: got %b/%b want %b/%b", n, inv_busy, inv_done, exp_busy, exp_done); end
      end
      rst_n = 1; rd_en = 0; wr_en = 0; inv_req = 0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_sweep();
      test_reset_mid_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
